key_ctrl: RTL
=============

# key_ctrl

Command controller behind the `key` debounce block. Consumes the four debounced, active-low key levels and arbitrates them into a single command stream of short-press, long-press and auto-repeat events. Delivers the stream over a valid/ready handshake to the heartbeat mode logic. Owns all press-duration timing; the `key` block owns only debounce.

## Interface
- `CLK_HZ`, 12_000_000: clock frequency; ms prescale = CLK_HZ/1000.
- `LONG_MS`, 1000: hold time in ms that produces a LONG command.
- `REPEAT_MS`, 200: interval in ms between REPEAT commands after LONG.
- `clk`  in  1  system clock, 12 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_n`  in  4  debounced key levels from `key`; 0 = pressed.
- `cmd_ready`  in  1  consumer accepts the command this cycle.
- `cmd_valid`  out  1  command pending.
- `cmd_key`  out  2  index of the key, 0..3.
- `cmd_type`  out  2  0 = SHORT, 1 = LONG, 2 = REPEAT; 3 is never driven.
- `cmd_drop`  out  1  one-cycle pulse: an event was lost because the slot was full.

## Operation
- `key_n` is registered once into `key_q` (reset value 4'b1111); the FSM uses only `key_q`.
- The FSM has four states:
  - WAIT_ALL (reset state): ignore keys. Go to IDLE when `key_q` == 4'b1111.
  - IDLE: exactly one bit of `key_q` low → latch its index, clear the ms prescaler and hold counter, go to PRESS. Two or more bits low → WAIT_ALL, no command.
  - PRESS: count ms ticks.
    - Held key released with hold < LONG_MS → emit SHORT, go to IDLE.
    - Hold reaches LONG_MS → emit LONG, clear the repeat counter, go to HOLD.
    - Any other key goes low → abort with no command, go to WAIT_ALL.
  - HOLD: emit REPEAT every REPEAT_MS.
    - Release of the held key → IDLE, no command.
    - Any other key pressed → WAIT_ALL.
- Priority within one cycle: second-key abort > release > LONG/REPEAT emission.
- Output slot holds one command:
  - An event with the slot empty, or with the slot full and `cmd_ready`=1 in the same cycle, loads the slot. The new command is visible the next cycle.
  - An event with `cmd_valid`=1 and `cmd_ready`=0 is discarded, `cmd_drop` pulses, and the pending command is unchanged.
- `cmd_key` and `cmd_type` are stable while `cmd_valid`=1 and `cmd_ready`=0.
- Width rules:
  - Prescaler width = clog2(CLK_HZ/1000).
  - Hold counter width = clog2(LONG_MS+1); it saturates at LONG_MS.
  - Repeat counter width = clog2(REPEAT_MS+1); it wraps to 0 at REPEAT_MS.
- Reset mid-operation: all state cleared, the slot is emptied, and the FSM enters WAIT_ALL. A key held across reset release therefore produces nothing until all keys are released.

## Timing
- Reset values: `cmd_valid`=0, `cmd_key`=0, `cmd_type`=0, `cmd_drop`=0.
- `key_n` change to FSM reaction: 1 cycle (the `key_q` register).
- SHORT: `cmd_valid` rises 2 edges after `key_n` release is sampled.
- LONG: `cmd_valid` rises LONG_MS·CLK_HZ/1000 + 2 cycles after the press edge of `key_n`.
- REPEAT: first REPEAT at REPEAT_MS·CLK_HZ/1000 cycles after LONG, then periodic with that spacing.
- Transfer completes on any edge with `cmd_valid`=`cmd_ready`=1; `cmd_valid` falls next cycle unless a new event is loaded.
- `cmd_drop` is high exactly 1 cycle per lost event.

## Structure
- `key_pkg`: `cmd_type` encodings (CMD_SHORT/LONG/REPEAT) and the FSM state enum (WAIT_ALL, IDLE, PRESS, HOLD).
- Sub-module `ms_tick`: prescaler with synchronous clear, emitting a 1-cycle tick every CLK_HZ/1000 clocks. The FSM, hold/repeat counters and output slot stay in `key_ctrl`.

## Test plan
Parameters for all scenarios: CLK_HZ=12000 (12 cycles/ms), LONG_MS=4, REPEAT_MS=2; `cmd_ready`=1 unless noted.
- Reset with `key_n`=4'b1111, then 1110 held for 20 cycles, then 1111 → one SHORT, `cmd_key`=0, `cmd_valid` high 1 cycle, 2 edges after release.
- 1101 held for 100 cycles → LONG key 1 at cycle 50 after press, REPEATs at 74 and 98; release gives no further command.
- 1100 applied from IDLE, then 1111 → no command; a subsequent 1011 tap → SHORT key 2.
- 0111 pressed, then 0110 added after 10 cycles → no command while either is held; FSM stays in WAIT_ALL until 1111.
- `cmd_ready`=0 and 1101 held for 100 cycles → LONG stays pending with stable fields; each REPEAT pulses `cmd_drop`; raising `cmd_ready` completes the LONG transfer.
- 1110 held and `rst_n` pulsed low mid-hold → outputs 0 immediately; no command until 1111 is seen, then a fresh tap gives SHORT.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types for the key command controller.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package key_pkg;

  typedef enum logic [1:0] {
    CMD_SHORT  = 2'd0,
    CMD_LONG   = 2'd1,
    CMD_REPEAT = 2'd2
  } cmd_type_e;

  typedef enum logic [1:0] {
    WAIT_ALL = 2'd0,
    IDLE     = 2'd1,
    PRESS    = 2'd2,
    HOLD     = 2'd3
  } state_e;

  // One pending command as held in the output slot.
  typedef struct packed {
    logic [1:0] key;
    cmd_type_e  typ;
  } cmd_t;

  // True when exactly one active-low key is pressed.
  function automatic logic single_low(input logic [3:0] k);
    case (k)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: single_low = 1'b1;
      default:                            single_low = 1'b0;
    endcase
  endfunction

  // Index of the single pressed key; only meaningful when single_low() is true.
  function automatic logic [1:0] low_index(input logic [3:0] k);
    case (k)
      4'b1101: low_index = 2'd1;
      4'b1011: low_index = 2'd2;
      4'b0111: low_index = 2'd3;
      default: low_index = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/ms_tick.sv
// Millisecond prescaler: one-cycle tick every DIV clocks, restartable by clr.
// Latency: first tick DIV cycles after the clearing edge.
// Backpressure: none; free-running.
module ms_tick #(
  parameter int DIV = 12_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 1));

  // Count 0..DIV-1 and wrap; clr restarts the millisecond phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/key_ctrl.sv
// Turns four debounced active-low keys into SHORT/LONG/REPEAT commands.
// Latency: key_n -> key_q 1 cycle, FSM decision 1 cycle, slot visible next cycle.
// Backpressure: one-entry slot; an event arriving while it is stalled is dropped and flagged on cmd_drop.
module key_ctrl
  import key_pkg::*;
#(
  parameter int CLK_HZ    = 12_000_000,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_n,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [1:0] cmd_key,
  output logic [1:0] cmd_type,
  output logic       cmd_drop
);

  localparam int PRESCALE = CLK_HZ / 1000;
  localparam int HW       = $clog2(LONG_MS + 1);
  localparam int RW       = $clog2(REPEAT_MS + 1);
  localparam logic [HW-1:0] LONG_CNT   = HW'(LONG_MS);
  localparam logic [RW-1:0] REPEAT_CNT = RW'(REPEAT_MS);

  logic [3:0]    key_q;
  logic          key_seen;
  state_e        state;
  logic [1:0]    held;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rep_cnt;
  cmd_t          slot;
  logic          tick;
  logic          presc_clr;
  logic [3:0]    held_mask;
  logic          others_low;
  logic          released;
  logic          evt_vld;
  cmd_type_e     evt_typ;

  assign cmd_key   = slot.key;
  assign cmd_type  = slot.typ;

  assign held_mask  = 4'b0001 << held;
  assign others_low = |(~key_q & ~held_mask);
  assign released   = key_q[held];
  assign presc_clr  = (state == IDLE) && single_low(key_q);

  ms_tick #(.DIV(PRESCALE)) u_ms_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (presc_clr),
    .tick  (tick)
  );

  // Sample the keys once; key_seen marks that key_q holds a real sample,
  // so a key held through reset is not mistaken for "all released".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q    <= 4'b1111;
      key_seen <= 1'b0;
    end else begin
      key_q    <= key_n;
      key_seen <= 1'b1;
    end
  end

  // Decode which command (if any) the FSM emits this cycle; abort beats release beats timing.
  always_comb begin
    evt_vld = 1'b0;
    evt_typ = CMD_SHORT;
    case (state)
      PRESS: begin
        if (!others_low) begin
          if (released) begin
            evt_vld = 1'b1;
            evt_typ = CMD_SHORT;
          end else if (hold_cnt == LONG_CNT) begin
            evt_vld = 1'b1;
            evt_typ = CMD_LONG;
          end
        end
      end
      HOLD: begin
        if (!others_low && !released && rep_cnt == REPEAT_CNT) begin
          evt_vld = 1'b1;
          evt_typ = CMD_REPEAT;
        end
      end
      default: ;
    endcase
  end

  // Press-tracking FSM with its hold/repeat counters and the registered output slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_ALL;
      held      <= 2'd0;
      hold_cnt  <= '0;
      rep_cnt   <= '0;
      cmd_valid <= 1'b0;
      slot      <= '0;
      cmd_drop  <= 1'b0;
    end else begin
      cmd_drop <= 1'b0;
      if (evt_vld) begin
        if (!cmd_valid || cmd_ready) begin
          cmd_valid <= 1'b1;
          slot.key  <= held;
          slot.typ  <= evt_typ;
        end else begin
          cmd_drop <= 1'b1;
        end
      end else if (cmd_ready) begin
        cmd_valid <= 1'b0;
      end

      case (state)
        WAIT_ALL: begin
          if (key_seen && key_q == 4'b1111) state <= IDLE;
        end
        IDLE: begin
          if (single_low(key_q)) begin
            held     <= low_index(key_q);
            hold_cnt <= '0;
            state    <= PRESS;
          end else if (key_q != 4'b1111) begin
            state <= WAIT_ALL;
          end
        end
        PRESS: begin
          if (others_low) begin
            state <= WAIT_ALL;
          end else if (released) begin
            state <= IDLE;
          end else if (hold_cnt == LONG_CNT) begin
            rep_cnt <= '0;
            state   <= HOLD;
          end else if (tick) begin
            // Leaving PRESS at LONG_CNT keeps the count saturated there.
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        HOLD: begin
          if (others_low) begin
            state <= WAIT_ALL;
          end else if (released) begin
            state <= IDLE;
          end else if (rep_cnt == REPEAT_CNT) begin
            // Wrap without losing a tick that lands on the wrap cycle.
            rep_cnt <= tick ? RW'(1) : '0;
          end else if (tick) begin
            rep_cnt <= rep_cnt + RW'(1);
          end
        end
        default: state <= WAIT_ALL;
      endcase
    end
  end

endmodule
